cbc_axi_read_master: RTL

AXI4 read master that serves the engine dispatcher's read-request interface in the CBC kernel. On a single-cycle `rmst_req` it fetches `rmst_xfer_size` bytes from global memory starting at `rmst_xfer_addr`. It issues INCR bursts on the AR channel and forwards R-channel data beats in order onto a 128-bit AXI4-Stream toward the dispatcher. When the last beat has been accepted downstream, it pulses `rmst_done`.

---
 rtl/cbc_axi_read_master.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cbc_axi_read_master.sv
// ============================================================================
// Module   : cbc_axi_read_master
// Purpose  : AXI4 INCR-burst read master streaming R beats to a 128-bit AXIS
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cbc_axi_read_master #(
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         aclk,
    input  logic         areset_n,
    input  logic         i_rmst_req,
    input  logic [63:0]  i_rmst_xfer_addr,
    input  logic [63:0]  i_rmst_xfer_size,
    output logic         o_rmst_done,
    output logic         o_m_axi_arvalid,
    input  logic         i_m_axi_arready,
    output logic [63:0]  o_m_axi_araddr,
    output logic [7:0]   o_m_axi_arlen,
    input  logic         i_m_axi_rvalid,
    output logic         o_m_axi_rready,
    input  logic [127:0] i_m_axi_rdata,
    input  logic         i_m_axi_rlast,
    output logic         o_axis_tvalid,
    input  logic         i_axis_tready,
    output logic [127:0] o_axis_tdata
);

    localparam int                c_OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [8:0]        c_MAX_BURST = 9'(MAX_BURST_LEN);
    localparam logic [c_OUT_W-1:0] c_MAX_OUT  = c_OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [63:0]          r_addr;
    logic [59:0]          r_ar_beats;
    logic [59:0]          r_rd_beats;
    logic [c_OUT_W-1:0]   r_outstanding;
    logic                 r_arvalid;
    logic [63:0]          r_araddr;
    logic [7:0]           r_arlen;
    logic                 r_done;

    logic                 w_run;
    logic [8:0]           w_page_beats;
    logic [8:0]           w_len;
    logic [8:0]           w_arlen_full;
    logic                 w_ar_issue;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_r_last_hs;
    logic                 w_unused_low_bits;

    assign w_run        = (r_state == S_RUN);
    // Beats left before the next 4 KB page; never crossed by a single burst.
    assign w_page_beats = 9'((13'd4096 - {1'b0, r_addr[11:0]}) >> 4);
    assign w_arlen_full = {1'b0, r_arlen} + 9'd1;
    assign w_ar_issue   = w_run && !r_arvalid && (r_ar_beats != 60'd0) &&
                          (r_outstanding < c_MAX_OUT);
    assign w_ar_hs      = r_arvalid && i_m_axi_arready;
    assign w_r_hs       = i_m_axi_rvalid && o_m_axi_rready;
    assign w_r_last_hs  = w_r_hs && i_m_axi_rlast;

    assign w_unused_low_bits = ^{i_rmst_xfer_addr[3:0], i_rmst_xfer_size[3:0]};

    always_comb begin
        w_len = w_page_beats;
        if (c_MAX_BURST < w_len) begin
            w_len = c_MAX_BURST;
        end
        if (r_ar_beats < {51'd0, w_len}) begin
            w_len = r_ar_beats[8:0];
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_ar_beats    <= '0;
            r_rd_beats    <= '0;
            r_outstanding <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_rmst_req) begin
                        r_addr        <= {i_rmst_xfer_addr[63:4], 4'h0};
                        r_ar_beats    <= i_rmst_xfer_size[63:4];
                        r_rd_beats    <= i_rmst_xfer_size[63:4];
                        r_outstanding <= '0;
                        if (i_rmst_xfer_size[63:4] == 60'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_ar_issue) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_addr;
                        r_arlen   <= 8'(w_len - 9'd1);
                    end
                    if (w_ar_hs) begin
                        r_arvalid  <= 1'b0;
                        r_addr     <= r_addr + {51'd0, w_arlen_full, 4'h0};
                        r_ar_beats <= r_ar_beats - {51'd0, w_arlen_full};
                    end
                    case ({w_ar_hs, w_r_last_hs})
                        2'b10:   r_outstanding <= r_outstanding + 1'b1;
                        2'b01:   r_outstanding <= r_outstanding - 1'b1;
                        default: r_outstanding <= r_outstanding;
                    endcase
                    if (w_r_hs) begin
                        r_rd_beats <= r_rd_beats - 60'd1;
                        if (r_rd_beats == 60'd1) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rmst_done     = r_done;
    assign o_m_axi_arvalid = r_arvalid;
    assign o_m_axi_araddr  = r_araddr;
    assign o_m_axi_arlen   = r_arlen;
    assign o_m_axi_rready  = i_axis_tready & w_run;
    assign o_axis_tvalid   = i_m_axi_rvalid & w_run;
    assign o_axis_tdata    = i_m_axi_rdata;

endmodule

`default_nettype wire
